// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: initiator for the register file write/read interface.
// After each reset, x1..NREGS-1 are loaded with INIT_VALUE. Commands then arrive
// on a valid/ready port. Read results are returned on a valid/ready port.
// Optional feature: define REGFILE_DUMP_EN to add a full register dump stream.
module regfile_access_ctrl #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5,
   parameter int NREGS = 32,
   parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_rs1,
   input  logic [ADDR_W-1:0] cmd_rs2,
   input  logic [ADDR_W-1:0] cmd_rd,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data1,
   output logic [DATA_W-1:0] rsp_data2,
   output logic              init_busy,
   output logic [ADDR_W-1:0] rf_rs1,
   output logic [ADDR_W-1:0] rf_rs2,
   output logic [ADDR_W-1:0] rf_rd,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              rf_regwrite,
   input  logic [DATA_W-1:0] rf_rdata1,
   input  logic [DATA_W-1:0] rf_rdata2,
   input  logic              dump_start,
   output logic              dump_valid,
   output logic [ADDR_W-1:0] dump_idx,
   output logic [DATA_W-1:0] dump_data
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_WRITE,
      S_READ,
      S_RESP
`ifdef REGFILE_DUMP_EN
      , S_DUMP
`endif
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              cmd_ready_d;
   logic              rsp_valid_d;
   logic [DATA_W-1:0] rsp_data1_d, rsp_data2_d;
   logic              init_busy_d;
   logic [ADDR_W-1:0] rf_rs1_d, rf_rs2_d, rf_rd_d;
   logic [DATA_W-1:0] rf_wdata_d;
   logic              rf_regwrite_d;

`ifdef REGFILE_DUMP_EN
   logic              dump_valid_d;
   logic [ADDR_W-1:0] dump_idx_d;
   logic [DATA_W-1:0] dump_data_d;
`else
   logic              unused_dump_start;

   // Without the dump feature the request is ignored and the stream is idle.
   assign unused_dump_start = dump_start;
   assign dump_valid = 1'b0;
   assign dump_idx   = '0;
   assign dump_data  = '0;
`endif

   // Next-state and next-output logic. All outputs are registered. Each state
   // computes the values the outputs take after the coming clock edge.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      cmd_ready_d   = cmd_ready;
      rsp_valid_d   = rsp_valid;
      rsp_data1_d   = rsp_data1;
      rsp_data2_d   = rsp_data2;
      init_busy_d   = init_busy;
      rf_rs1_d      = rf_rs1;
      rf_rs2_d      = rf_rs2;
      rf_rd_d       = rf_rd;
      rf_wdata_d    = rf_wdata;
      rf_regwrite_d = 1'b0;
`ifdef REGFILE_DUMP_EN
      dump_valid_d  = 1'b0;
      dump_idx_d    = dump_idx;
      dump_data_d   = dump_data;
`endif
      case (state_q)
         S_INIT: begin
            rf_rd_d       = idx_q;
            rf_wdata_d    = INIT_VALUE;
            rf_regwrite_d = 1'b1;
            init_busy_d   = 1'b1;
            idx_d         = idx_q + ADDR_W'(1);
            if (idx_q == LAST_IDX) begin
               state_d = S_IDLE;
            end
         end
         S_IDLE: begin
            init_busy_d = 1'b0;
            cmd_ready_d = 1'b1;
            if (cmd_ready) begin
`ifdef REGFILE_DUMP_EN
               if (dump_start) begin
                  state_d     = S_DUMP;
                  cmd_ready_d = 1'b0;
                  rf_rs1_d    = '0;
               end else
`endif
               if (cmd_valid) begin
                  cmd_ready_d = 1'b0;
                  if (cmd_write) begin
                     state_d       = S_WRITE;
                     rf_rd_d       = cmd_rd;
                     rf_wdata_d    = cmd_wdata;
                     rf_regwrite_d = (cmd_rd != '0);
                  end else begin
                     state_d  = S_READ;
                     rf_rs1_d = cmd_rs1;
                     rf_rs2_d = cmd_rs2;
                  end
               end
            end
         end
         S_WRITE: begin
            state_d     = S_IDLE;
            cmd_ready_d = 1'b1;
         end
         S_READ: begin
            rsp_data1_d = rf_rdata1;
            rsp_data2_d = rf_rdata2;
            state_d     = S_RESP;
         end
         S_RESP: begin
            rsp_valid_d = 1'b1;
            if (rsp_valid && rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
`ifdef REGFILE_DUMP_EN
         S_DUMP: begin
            dump_valid_d = 1'b1;
            dump_idx_d   = rf_rs1;
            dump_data_d  = rf_rdata1;
            if (rf_rs1 == LAST_IDX) begin
               state_d     = S_IDLE;
               cmd_ready_d = 1'b1;
            end else begin
               rf_rs1_d = rf_rs1 + ADDR_W'(1);
            end
         end
`endif
         default: begin
            state_d = S_INIT;
         end
      endcase
   end

   // State and output registers; reset restarts the init sequence from x1.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_INIT;
         idx_q       <= ADDR_W'(1);
         cmd_ready   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_data1   <= '0;
         rsp_data2   <= '0;
         init_busy   <= 1'b1;
         rf_rs1      <= '0;
         rf_rs2      <= '0;
         rf_rd       <= '0;
         rf_wdata    <= '0;
         rf_regwrite <= 1'b0;
`ifdef REGFILE_DUMP_EN
         dump_valid  <= 1'b0;
         dump_idx    <= '0;
         dump_data   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cmd_ready   <= cmd_ready_d;
         rsp_valid   <= rsp_valid_d;
         rsp_data1   <= rsp_data1_d;
         rsp_data2   <= rsp_data2_d;
         init_busy   <= init_busy_d;
         rf_rs1      <= rf_rs1_d;
         rf_rs2      <= rf_rs2_d;
         rf_rd       <= rf_rd_d;
         rf_wdata    <= rf_wdata_d;
         rf_regwrite <= rf_regwrite_d;
`ifdef REGFILE_DUMP_EN
         dump_valid  <= dump_valid_d;
         dump_idx    <= dump_idx_d;
         dump_data   <= dump_data_d;
`endif
      end
   end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed testbench for regfile_access_ctrl with a behavioural register file.
// The register file model loads garbage on reset so that the init sequence is visible.
module tb_regfile_access_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [4:0]  cmd_rs1, cmd_rs2, cmd_rd;
   logic [63:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_data1, rsp_data2;
   logic        init_busy;
   logic [4:0]  rf_rs1, rf_rs2, rf_rd;
   logic [63:0] rf_wdata;
   logic        rf_regwrite;
   logic [63:0] rf_rdata1, rf_rdata2;
   logic        dump_start;
   logic        dump_valid;
   logic [4:0]  dump_idx;
   logic [63:0] dump_data;

   int passCount = 0;
   int checkCount = 0;

   regfile_access_ctrl dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data1(rsp_data1), .rsp_data2(rsp_data2), .init_busy(init_busy),
      .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
      .rf_regwrite(rf_regwrite), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .dump_start(dump_start), .dump_valid(dump_valid),
      .dump_idx(dump_idx), .dump_data(dump_data)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Register file: write at posedge, x0 reads zero, garbage loaded while in reset.
   logic [63:0] regs [32];
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= 64'hDEAD_BEEF_0000_0000 | 64'(i);
      end else if (rf_regwrite && rf_rd != 5'd0) begin
         regs[rf_rd] <= rf_wdata;
      end
   end
   assign rf_rdata1 = (rf_rs1 == 5'd0) ? 64'd0 : regs[rf_rs1];
   assign rf_rdata2 = (rf_rs2 == 5'd0) ? 64'd0 : regs[rf_rs2];

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a command and returns #1 after the edge that accepts it.
   task automatic applyStimulus(input logic wr, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [63:0] wdata);
      logic accepted;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_rs1 = rs1;
      cmd_rs2 = rs2;
      cmd_rd = rd;
      cmd_wdata = wdata;
      accepted = 1'b0;
      for (int i = 0; i < 64 && !accepted; i++) begin
         if (cmd_ready === 1'b1) accepted = 1'b1;
         tick();
      end
      cmd_valid = 1'b0;
      if (!accepted) checkOutput("cmdAcceptTimeout", 64'(accepted), 64'd1);
   endtask

   // Issues a read and checks latency, data and the response handshake.
   task automatic readCheck(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [63:0] exp1, input logic [63:0] exp2);
      applyStimulus(1'b0, rs1, rs2, 5'd0, 64'd0);
      tick();
      checkOutput({tag, "_validEarly"}, 64'(rsp_valid), 64'd0);
      tick();
      checkOutput({tag, "_valid"}, 64'(rsp_valid), 64'd1);
      checkOutput({tag, "_data1"}, rsp_data1, exp1);
      checkOutput({tag, "_data2"}, rsp_data2, exp2);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkOutput({tag, "_validDrop"}, 64'(rsp_valid), 64'd0);
      checkOutput({tag, "_readyBack"}, 64'(cmd_ready), 64'd1);
   endtask

   initial begin
      int waited;
      int beats;
      logic sawValid;
      reset = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_rs1 = '0;
      cmd_rs2 = '0;
      cmd_rd = '0;
      cmd_wdata = '0;
      rsp_ready = 1'b0;
      dump_start = 1'b0;

      // Test 1: reset values, then the 31-cycle init sequence.
      tick();
      tick();
      checkOutput("rstCmdReady", 64'(cmd_ready), 64'd0);
      checkOutput("rstRspValid", 64'(rsp_valid), 64'd0);
      checkOutput("rstInitBusy", 64'(init_busy), 64'd1);
      checkOutput("rstRegWrite", 64'(rf_regwrite), 64'd0);
      checkOutput("rstRfRd", 64'(rf_rd), 64'd0);
      checkOutput("rstDumpValid", 64'(dump_valid), 64'd0);
      reset = 1'b0;
      for (int k = 1; k <= 31; k++) begin
         tick();
         checkOutput("initRegWrite", 64'(rf_regwrite), 64'd1);
         checkOutput("initRd", 64'(rf_rd), 64'(k));
         checkOutput("initWdata", rf_wdata, 64'd0);
         checkOutput("initBusy", 64'(init_busy), 64'd1);
         checkOutput("initCmdReady", 64'(cmd_ready), 64'd0);
      end
      tick();
      checkOutput("initDoneRegWrite", 64'(rf_regwrite), 64'd0);
      checkOutput("initDoneBusy", 64'(init_busy), 64'd0);
      checkOutput("initDoneCmdReady", 64'(cmd_ready), 64'd1);

      // Test 2: write x2, then read it back alongside an initialised register.
      applyStimulus(1'b1, 5'd0, 5'd0, 5'd2, 64'h0F0F0F0F0F0F0F0F);
      checkOutput("wrRegWrite", 64'(rf_regwrite), 64'd1);
      checkOutput("wrRd", 64'(rf_rd), 64'd2);
      checkOutput("wrWdata", rf_wdata, 64'h0F0F0F0F0F0F0F0F);
      checkOutput("wrCmdReady", 64'(cmd_ready), 64'd0);
      tick();
      checkOutput("wrDoneRegWrite", 64'(rf_regwrite), 64'd0);
      checkOutput("wrDoneCmdReady", 64'(cmd_ready), 64'd1);
      readCheck("rd2_4", 5'd2, 5'd4, 64'h0F0F0F0F0F0F0F0F, 64'd0);

      // Test 3: writes to x0 never assert RegWrite; x0 reads zero.
      applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 64'hFFFFFFFFFFFFFFFF);
      checkOutput("wrX0RegWrite", 64'(rf_regwrite), 64'd0);
      tick();
      checkOutput("wrX0RegWrite2", 64'(rf_regwrite), 64'd0);
      readCheck("rdX0", 5'd0, 5'd2, 64'd0, 64'h0F0F0F0F0F0F0F0F);

      // Test 4: response held under backpressure; a pending command waits.
      applyStimulus(1'b0, 5'd2, 5'd0, 5'd0, 64'd0);
      tick();
      tick();
      checkOutput("bpValid", 64'(rsp_valid), 64'd1);
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_rd = 5'd3;
      cmd_wdata = 64'h33;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("bpHoldValid", 64'(rsp_valid), 64'd1);
         checkOutput("bpHoldData1", rsp_data1, 64'h0F0F0F0F0F0F0F0F);
         checkOutput("bpHoldData2", rsp_data2, 64'd0);
         checkOutput("bpHoldCmdReady", 64'(cmd_ready), 64'd0);
         checkOutput("bpHoldRegWrite", 64'(rf_regwrite), 64'd0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkOutput("bpHsValid", 64'(rsp_valid), 64'd0);
      checkOutput("bpHsCmdReady", 64'(cmd_ready), 64'd1);
      checkOutput("bpHsNoAccept", 64'(rf_regwrite), 64'd0);
      tick();
      cmd_valid = 1'b0;
      checkOutput("bpLateAccept", 64'(rf_regwrite), 64'd1);
      checkOutput("bpLateRd", 64'(rf_rd), 64'd3);
      checkOutput("bpLateWdata", rf_wdata, 64'h33);
      tick();

      // Test 5: reset during a pending response drops it and re-runs init.
      applyStimulus(1'b0, 5'd3, 5'd2, 5'd0, 64'd0);
      tick();
      tick();
      checkOutput("preRstValid", 64'(rsp_valid), 64'd1);
      checkOutput("preRstData1", rsp_data1, 64'h33);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("midRstValid", 64'(rsp_valid), 64'd0);
      checkOutput("midRstBusy", 64'(init_busy), 64'd1);
      checkOutput("midRstCmdReady", 64'(cmd_ready), 64'd0);
      checkOutput("midRstData1", rsp_data1, 64'd0);
      waited = 0;
      while (cmd_ready !== 1'b1 && waited < 40) begin
         tick();
         waited++;
      end
      checkOutput("reinitCycles", 64'(waited), 64'd32);
      readCheck("rdAfterRst", 5'd2, 5'd31, 64'd0, 64'd0);

      // Test 6: register dump (or its absence in the default build).
      applyStimulus(1'b1, 5'd0, 5'd0, 5'd5, 64'hA5);
      tick();
      checkOutput("preDumpCmdReady", 64'(cmd_ready), 64'd1);
`ifdef REGFILE_DUMP_EN
      dump_start = 1'b1;
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_rd = 5'd6;
      cmd_wdata = 64'h66;
      tick();
      dump_start = 1'b0;
      cmd_valid = 1'b0;
      checkOutput("dumpPrioRegWrite", 64'(rf_regwrite), 64'd0);
      checkOutput("dumpCmdReady", 64'(cmd_ready), 64'd0);
      beats = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (dump_valid === 1'b1) begin
            checkOutput("dumpIdx", 64'(dump_idx), 64'(beats));
            if (beats == 0) checkOutput("dumpX0", dump_data, 64'd0);
            if (beats == 2) checkOutput("dumpX2", dump_data, 64'd0);
            if (beats == 5) checkOutput("dumpX5", dump_data, 64'hA5);
            if (beats == 10) checkOutput("dumpBusyReady", 64'(cmd_ready), 64'd0);
            beats++;
         end else if (beats > 0 && beats < 32) begin
            checkOutput("dumpGap", 64'(beats), 64'd32);
            beats = 99;
         end
      end
      checkOutput("dumpBeats", 64'(beats), 64'd32);
      checkOutput("dumpEndReady", 64'(cmd_ready), 64'd1);
`else
      dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      checkOutput("noDumpCmdReady", 64'(cmd_ready), 64'd1);
      sawValid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (dump_valid !== 1'b0) sawValid = 1'b1;
      end
      checkOutput("noDumpValid", 64'(sawValid), 64'd0);
      beats = 0;
`endif

      $display("[TB] directed sequence complete");
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
